// File: rtl/dff_2_pkg.sv
// rtl/dff_2_pkg.sv - shared defaults for the dff_2 storage cell
package dff_2_pkg;

  localparam int DFF_2_WIDTH = 1;

endpackage

// File: rtl/dff_2_d_latch.sv
// rtl/dff_2_d_latch.sv - level-sensitive D latch, transparent while en is high
module d_latch (
  input  logic en,
  input  logic d,
  output logic q,
  output logic qb
);

  always_latch begin
    if (en) q <= d;
  end

  assign qb = ~q;

endmodule

// File: rtl/dff_2.sv
// rtl/dff_2.sv - master-slave D flip-flop with synchronous clear and complementary outputs
module dff_2
  import dff_2_pkg::*;
#(
  parameter int               WIDTH       = DFF_2_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  logic             clk_n;
  logic [WIDTH-1:0] d_eff;
  logic [WIDTH-1:0] master_q;
  logic [WIDTH-1:0] master_qb;

  assign clk_n = ~clk;
  // Clear is muxed in ahead of the master so it only takes effect at a rising edge.
  assign d_eff = clear ? RESET_VALUE : d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_latch u_master (
      .en (clk_n),
      .d  (d_eff[i]),
      .q  (master_q[i]),
      .qb (master_qb[i])
    );

    d_latch u_slave (
      .en (clk),
      .d  (master_q[i]),
      .q  (q[i]),
      .qb (qb[i])
    );
  end

`ifndef SYNTHESIS
  logic clear_seen;

  always @(posedge clk) clear_seen <= clear;

  always @(negedge clk) begin
    assert (qb === ~q) else $error("dff_2: qb is not the complement of q");
    assert (master_qb === ~master_q) else $error("dff_2: master latch outputs disagree");
    if (clear_seen === 1'b1) begin
      assert (q === RESET_VALUE) else $error("dff_2: q did not load RESET_VALUE after clear");
    end
  end
`endif

endmodule

// File: tb/tb_dff_2.sv
// tb/tb_dff_2.sv - scoreboard bench for dff_2 at default and 4-bit parameters
module tb_dff_2;

  typedef struct packed {
    logic       q1;
    logic [3:0] q4;
  } exp_t;

  logic       clk;
  logic       clear;
  logic [0:0] d1;
  logic [0:0] q1;
  logic [0:0] qb1;
  logic [3:0] d4;
  logic [3:0] q4;
  logic [3:0] qb4;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  dff_2 u_dut1 (
    .clk   (clk),
    .clear (clear),
    .d     (d1),
    .q     (q1),
    .qb    (qb1)
  );

  dff_2 #(.WIDTH(4), .RESET_VALUE(4'hA)) u_dut4 (
    .clk   (clk),
    .clear (clear),
    .d     (d4),
    .q     (q4),
    .qb    (qb4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs and push what both cells must hold after the next rising edge.
  task automatic drive(input logic c, input logic dv1, input logic [3:0] dv4);
    exp_t e;
    clear = c;
    d1    = dv1;
    d4    = dv4;
    e.q1  = c ? 1'b0 : dv1;
    e.q4  = c ? 4'hA : dv4;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q1"},  {3'b0, q1},  {3'b0, e.q1});
      chk({tag, "_qb1"}, {3'b0, qb1}, {3'b0, ~e.q1});
      chk({tag, "_q4"},  q4,  e.q4);
      chk({tag, "_qb4"}, qb4, ~e.q4);
    end
  endtask

  initial begin
    drive(1'b1, 1'b1, 4'h7);
    tick("reset");

    #1 drive(1'b0, 1'b1, 4'h3);
    tick("release");

    #1 drive(1'b0, 1'b0, 4'h9);
    #4;
    chk("fall_hold_q1", {3'b0, q1}, 4'h1);
    chk("fall_hold_q4", q4, 4'h3);
    tick("follow");

    #1 drive(1'b0, 1'b1, 4'h6);
    #4 clear = 1'b1;
    #2 clear = 1'b0;
    tick("glitch");

    for (int i = 0; i < 7; i++) begin
      #1 drive(1'b1, 1'($urandom), 4'($urandom));
      tick("clear_pri");
    end

    for (int i = 0; i < 8; i++) begin
      #1 drive(1'b0, 1'($urandom), 4'($urandom));
      tick("random");
    end

    #1 drive(1'b0, 1'b0, 4'h3);
    #1 clear = 1'b1;
    #1 clear = 1'b0;
    tick("late_glitch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
